multicycle_cu: RTL

Parametrised multi-cycle control unit; successor to the single-cycle `cu`. It sequences each instruction through FETCH / DECODE / EXECUTE / MEMORY / WRITEBACK states and drives the same control strobes (`Branch`, `ALUSrc`, `RegWrite`, `ALUControl`) plus memory, IR and PC strobes. It adds two handshakes, instruction fetch and data memory, and keeps a retired-instruction counter. It sits between the instruction/data memory interfaces and the register file / ALU datapath.

---
 rtl/cu_pkg.sv | 42 ++++
 rtl/cu_decode.sv | 61 ++++++
 rtl/multicycle_cu.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/cu_pkg.sv
// Shared types and constants for the multi-cycle control unit.
//   state_t  : FSM phases an instruction walks through
//   opcode_e : the eight mapped opcodes (low three opcode bits)
//   ALU_*    : two-bit ALU operation codes
//   ctrl_t   : decoded per-instruction control word produced by cu_decode
package cu_pkg;

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEMORY    = 3'd3,
    WRITEBACK = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    OP_ADD   = 3'd0,
    OP_SUB   = 3'd1,
    OP_AND   = 3'd2,
    OP_OR    = 3'd3,
    OP_ADDI  = 3'd4,
    OP_LOAD  = 3'd5,
    OP_STORE = 3'd6,
    OP_BEQ   = 3'd7
  } opcode_e;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  typedef struct packed {
    logic       alusrc;
    logic [1:0] aluctrl;
    logic       is_load;
    logic       is_store;
    logic       is_branch;
    logic       writes_reg;
    logic       legal;
  } ctrl_t;

endpackage

// File: rtl/cu_decode.sv
// Combinational instruction decode: latched opcode -> control word.
// Ports:
//   op   in  OPCODE_W  latched opcode (op_q of the FSM)
//   ctrl out ctrl_t    decoded controls; all-zero (legal = 0) for unmapped opcodes
module cu_decode
  import cu_pkg::*;
#(
  parameter int OPCODE_W = 4
) (
  input  logic [OPCODE_W-1:0] op,
  output ctrl_t               ctrl
);

  // Only opcodes whose upper bits are all zero are mapped; everything else
  // leaves the control word at zero, which the FSM reads as illegal.
  always_comb begin
    ctrl = '0;
    if (op[OPCODE_W-1:3] == '0) begin
      ctrl.legal = 1'b1;
      case (opcode_e'(op[2:0]))
        OP_ADD: begin
          ctrl.aluctrl    = ALU_ADD;
          ctrl.writes_reg = 1'b1;
        end
        OP_SUB: begin
          ctrl.aluctrl    = ALU_SUB;
          ctrl.writes_reg = 1'b1;
        end
        OP_AND: begin
          ctrl.aluctrl    = ALU_AND;
          ctrl.writes_reg = 1'b1;
        end
        OP_OR: begin
          ctrl.aluctrl    = ALU_OR;
          ctrl.writes_reg = 1'b1;
        end
        OP_ADDI: begin
          ctrl.alusrc     = 1'b1;
          ctrl.aluctrl    = ALU_ADD;
          ctrl.writes_reg = 1'b1;
        end
        OP_LOAD: begin
          ctrl.alusrc     = 1'b1;
          ctrl.aluctrl    = ALU_ADD;
          ctrl.is_load    = 1'b1;
          ctrl.writes_reg = 1'b1;
        end
        OP_STORE: begin
          ctrl.alusrc   = 1'b1;
          ctrl.aluctrl  = ALU_ADD;
          ctrl.is_store = 1'b1;
        end
        OP_BEQ: begin
          ctrl.aluctrl   = ALU_SUB;
          ctrl.is_branch = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/multicycle_cu.sv
// Multi-cycle control unit: sequences each instruction through
// FETCH / DECODE / EXECUTE / MEMORY / WRITEBACK, with a fetch handshake,
// a data-memory handshake and a retired-instruction counter.
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   opcode, instr_valid  fetch bus; instr_ready high in FETCH
//   mem_ready            data memory completes the access
//   zero                 ALU zero flag, used by BEQ in EXECUTE
//   IRWrite, PCWrite     IR load / PC update strobes
//   Branch, ALUSrc       PC source select / ALU B operand select
//   ALUControl           ALU op (upper bits above 2 are zero)
//   MemRead, MemWrite    data memory requests
//   RegWrite             register file write strobe
//   illegal_op           one-cycle pulse in DECODE for an unmapped opcode
//   retired              wrapping count of completed legal instructions
module multicycle_cu
  import cu_pkg::*;
#(
  parameter int OPCODE_W  = 4,
  parameter int ALUCTRL_W = 2,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [OPCODE_W-1:0]  opcode,
  input  logic                 instr_valid,
  output logic                 instr_ready,
  input  logic                 mem_ready,
  input  logic                 zero,
  output logic                 IRWrite,
  output logic                 PCWrite,
  output logic                 Branch,
  output logic                 ALUSrc,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic                 MemRead,
  output logic                 MemWrite,
  output logic                 RegWrite,
  output logic                 illegal_op,
  output logic [CNT_W-1:0]     retired
);

  state_t              state;
  state_t              state_n;
  logic [OPCODE_W-1:0] op_q;
  ctrl_t               ctrl;
  logic [1:0]          alu_op;
  logic                retire;

  cu_decode #(
    .OPCODE_W(OPCODE_W)
  ) u_decode (
    .op  (op_q),
    .ctrl(ctrl)
  );

  // State register, opcode latch and retired counter. The opcode is only
  // captured on a fetch accept, so everything after FETCH decodes from op_q.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= FETCH;
      op_q    <= '0;
      retired <= '0;
    end else begin
      state <= state_n;
      if (IRWrite) begin
        op_q <= opcode;
      end
      if (retire) begin
        retired <= retired + CNT_W'(1);
      end
    end
  end

  // Next-state and strobe decode. Every strobe defaults to zero, so each
  // state only raises what it owns; retire marks the completing cycle.
  always_comb begin
    state_n     = state;
    instr_ready = 1'b0;
    IRWrite     = 1'b0;
    PCWrite     = 1'b0;
    Branch      = 1'b0;
    ALUSrc      = 1'b0;
    alu_op      = ALU_ADD;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    RegWrite    = 1'b0;
    illegal_op  = 1'b0;
    retire      = 1'b0;
    case (state)
      FETCH: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_n = DECODE;
        end
      end
      DECODE: begin
        if (ctrl.legal) begin
          state_n = EXECUTE;
        end else begin
          illegal_op = 1'b1;
          state_n    = FETCH;
        end
      end
      EXECUTE: begin
        ALUSrc = ctrl.alusrc;
        alu_op = ctrl.aluctrl;
        if (ctrl.is_branch) begin
          Branch  = 1'b1;
          PCWrite = zero;
          retire  = 1'b1;
          state_n = FETCH;
        end else if (ctrl.is_load || ctrl.is_store) begin
          state_n = MEMORY;
        end else begin
          state_n = WRITEBACK;
        end
      end
      MEMORY: begin
        ALUSrc   = 1'b1;
        alu_op   = ALU_ADD;
        MemRead  = ctrl.is_load;
        MemWrite = ctrl.is_store;
        if (mem_ready) begin
          if (ctrl.is_load) begin
            state_n = WRITEBACK;
          end else begin
            retire  = 1'b1;
            state_n = FETCH;
          end
        end
      end
      WRITEBACK: begin
        RegWrite = ctrl.writes_reg;
        retire   = 1'b1;
        state_n  = FETCH;
      end
      default: begin
        state_n = FETCH;
      end
    endcase
  end

  assign ALUControl = ALUCTRL_W'(alu_op);

endmodule
